// File: rtl/vco_adc_scheduler_if.sv
// Result handshake between the VCO ADC conversion sequencer and its consumer.
interface vco_adc_scheduler_if #(
    parameter int CNT_W = 16
);
    logic             res_valid;
    logic             res_ready;
    logic [CNT_W-1:0] res_data;
    logic [1:0]       res_ch;

    modport master (output res_valid, res_data, res_ch, input res_ready);
    modport slave  (input res_valid, res_data, res_ch, output res_ready);
endinterface

// File: rtl/vco_adc_scheduler.sv
// Round-robin conversion sequencer for the VCO ADC channels: settle, integrate,
// capture and hand out one count per enabled channel, optionally sweeping forever.
module vco_adc_scheduler #(
    parameter int NUM_CH = 3,
    parameter int CNT_W  = 16,
    parameter int WIN_W  = 16,
    parameter int SET_W  = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                continuous,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [WIN_W-1:0]    win_len,
    input  logic [SET_W-1:0]    settle_len,
    output logic [NUM_CH-1:0]   vco_en,
    output logic                cnt_clr,
    output logic [1:0]          ch_sel,
    input  logic [CNT_W-1:0]    cnt_value,
    output logic                busy,
    output logic                sweep_done,
    vco_adc_scheduler_if.master res_if
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_INTEG,
        ST_CAPTURE,
        ST_OUTPUT
    } state_t;

    state_t            state_q, state_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [1:0]        ch_sel_q, ch_sel_d;
    logic [SET_W-1:0]  set_cnt_q, set_cnt_d;
    logic [WIN_W-1:0]  win_cnt_q, win_cnt_d;
    logic [CNT_W-1:0]  res_data_q, res_data_d;
    logic [1:0]        res_ch_q, res_ch_d;
    logic              res_valid_q, res_valid_d;
    logic [NUM_CH-1:0] vco_en_q, vco_en_d;
    logic              cnt_clr_q, cnt_clr_d;
    logic              busy_q, busy_d;
    logic              sweep_done_q, sweep_done_d;

    logic [SET_W-1:0]  settle_load;
    logic [WIN_W-1:0]  win_load;
    logic [NUM_CH-1:0] sel_onehot;
    logic              lo_hit, nx_hit;
    logic [1:0]        lo_idx, nx_idx;

    // A zero length still spends one cycle in the state, so counters never wrap.
    assign settle_load = (settle_len == '0) ? SET_W'(1) : settle_len;
    assign win_load    = (win_len == '0) ? WIN_W'(1) : win_len;

    // Lowest channel of the live mask (new sweep) and next latched channel above ch_sel.
    always_comb begin
        lo_hit = 1'b0;
        lo_idx = 2'd0;
        nx_hit = 1'b0;
        nx_idx = 2'd0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                lo_hit = 1'b1;
                lo_idx = 2'(i);
            end
            if (mask_q[i] && (i > int'(ch_sel_q))) begin
                nx_hit = 1'b1;
                nx_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        ch_sel_d     = ch_sel_q;
        set_cnt_d    = set_cnt_q;
        win_cnt_d    = win_cnt_q;
        res_data_d   = res_data_q;
        res_ch_d     = res_ch_q;
        sweep_done_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && lo_hit) begin
                    mask_d    = ch_mask;
                    ch_sel_d  = lo_idx;
                    set_cnt_d = settle_load;
                    state_d   = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (set_cnt_q <= SET_W'(1)) begin
                    win_cnt_d = win_load;
                    state_d   = ST_INTEG;
                end else begin
                    set_cnt_d = set_cnt_q - SET_W'(1);
                end
            end
            ST_INTEG: begin
                if (win_cnt_q <= WIN_W'(1)) begin
                    state_d = ST_CAPTURE;
                end else begin
                    win_cnt_d = win_cnt_q - WIN_W'(1);
                end
            end
            ST_CAPTURE: begin
                res_data_d = cnt_value;
                res_ch_d   = ch_sel_q;
                state_d    = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (res_if.res_ready) begin
                    if (nx_hit) begin
                        ch_sel_d  = nx_idx;
                        set_cnt_d = settle_load;
                        state_d   = ST_SETTLE;
                    end else begin
                        sweep_done_d = 1'b1;
                        if (continuous && lo_hit) begin
                            mask_d    = ch_mask;
                            ch_sel_d  = lo_idx;
                            set_cnt_d = settle_load;
                            state_d   = ST_SETTLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sel
        assign sel_onehot[gi] = (ch_sel_d == 2'(gi));
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_comb begin
        res_valid_d = (state_d == ST_OUTPUT);
        busy_d      = (state_d != ST_IDLE);
        vco_en_d    = ((state_d == ST_SETTLE) || (state_d == ST_INTEG)) ? sel_onehot : '0;
        cnt_clr_d   = !((state_d == ST_INTEG) || (state_d == ST_CAPTURE));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            mask_q       <= '0;
            ch_sel_q     <= 2'd0;
            set_cnt_q    <= '0;
            win_cnt_q    <= '0;
            res_data_q   <= '0;
            res_ch_q     <= 2'd0;
            res_valid_q  <= 1'b0;
            vco_en_q     <= '0;
            cnt_clr_q    <= 1'b1;
            busy_q       <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mask_q       <= mask_d;
            ch_sel_q     <= ch_sel_d;
            set_cnt_q    <= set_cnt_d;
            win_cnt_q    <= win_cnt_d;
            res_data_q   <= res_data_d;
            res_ch_q     <= res_ch_d;
            res_valid_q  <= res_valid_d;
            vco_en_q     <= vco_en_d;
            cnt_clr_q    <= cnt_clr_d;
            busy_q       <= busy_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign vco_en           = vco_en_q;
    assign cnt_clr          = cnt_clr_q;
    assign ch_sel           = ch_sel_q;
    assign busy             = busy_q;
    assign sweep_done       = sweep_done_q;
    assign res_if.res_valid = res_valid_q;
    assign res_if.res_data  = res_data_q;
    assign res_if.res_ch    = res_ch_q;
endmodule

// File: tb/tb_vco_adc_scheduler.sv
// Self-checking bench for vco_adc_scheduler: table of sweeps, randomized sweeps against
// a transaction-level model, and hand sequences for reset, back-pressure and continuous mode.
module tb_vco_adc_scheduler;
    localparam int NUM_CH = 3;
    localparam int CNT_W  = 16;
    localparam int WIN_W  = 16;
    localparam int SET_W  = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              continuous = 1'b0;
    logic [NUM_CH-1:0] ch_mask = '0;
    logic [WIN_W-1:0]  win_len = '0;
    logic [SET_W-1:0]  settle_len = '0;
    logic [NUM_CH-1:0] vco_en;
    logic              cnt_clr;
    logic [1:0]        ch_sel;
    logic [CNT_W-1:0]  cnt_value;
    logic              busy;
    logic              sweep_done;

    vco_adc_scheduler_if #(.CNT_W(CNT_W)) rif ();

    vco_adc_scheduler #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .WIN_W(WIN_W), .SET_W(SET_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .ch_mask(ch_mask), .win_len(win_len), .settle_len(settle_len),
        .vco_en(vco_en), .cnt_clr(cnt_clr), .ch_sel(ch_sel), .cnt_value(cnt_value),
        .busy(busy), .sweep_done(sweep_done), .res_if(rif)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural VCO counters: cleared while selected with cnt_clr, count rate[c] per enabled cycle.
    int cnt  [NUM_CH];
    int rate [NUM_CH];
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) cnt[c] <= 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (cnt_clr && int'(ch_sel) == c) cnt[c] <= 0;
                else if (vco_en[c])               cnt[c] <= cnt[c] + rate[c];
            end
        end
    end
    always_comb begin
        cnt_value = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (int'(ch_sel) == c) cnt_value = CNT_W'(c * 1000 + 7 + cnt[c]);
    end

    // Random ready driver, active only when rmode is set.
    bit rmode = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rmode) rif.res_ready = 1'($urandom_range(0, 1));
    end

    typedef struct {int ch; int data; int t;} acc_t;
    acc_t acc_q[$];
    acc_t exp_q[$];
    int   rise_q[$];
    int   done_q[$];
    bit   done_busy_q[$];
    logic valid_prev = 1'b0;
    logic [NUM_CH-1:0] allow_mask = '0;

    // Monitor: handshakes, result-valid rises, sweep_done pulses, and VCO enable legality.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rif.res_valid && !valid_prev) rise_q.push_back(cyc);
            if (rif.res_valid && rif.res_ready)
                acc_q.push_back('{int'(rif.res_ch), int'(rif.res_data), cyc});
            if (sweep_done) begin
                done_q.push_back(cyc);
                done_busy_q.push_back(busy);
            end
            checks++;
            if ($countones(vco_en) > 1 || (vco_en & ~allow_mask) != '0 ||
                (rif.res_valid && vco_en != '0)) begin
                errors++;
                $display("FAIL vco_en_legal: got vco_en=%b valid=%0b, want one-hot within %b and 0 during output",
                         vco_en, rif.res_valid, allow_mask);
            end
        end
        valid_prev <= rif.res_valid;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int eff(input int x);
        return (x == 0) ? 1 : x;
    endfunction

    task automatic clear_obs();
        acc_q.delete();
        rise_q.delete();
        done_q.delete();
        done_busy_q.delete();
    endtask

    // One non-continuous sweep; optional noise = mask change plus a start pulse while busy.
    task automatic run_sweep(input logic [2:0] m, input int s, input int w, input bit noise,
                             output int t0);
        int k;
        clear_obs();
        ch_mask    = m;
        settle_len = SET_W'(s);
        win_len    = WIN_W'(w);
        allow_mask = m;
        start      = 1'b1;
        t0         = cyc;
        tick();
        start = 1'b0;
        k = 0;
        while (done_q.size() == 0 && k < 3000 && !(m == 3'b000 && k >= 10)) begin
            if (noise && m != 3'b000 && k == 1) begin
                ch_mask = 3'($urandom);
                start   = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            k++;
        end
        start = 1'b0;
        if (m != 3'b000 && done_q.size() == 0) chk("sweep_timeout", 0, 1);
        tick();
        tick();
    endtask

    // Compare observed sweep against model: result order/data, latency per channel, done pulse.
    task automatic check_sweep(input string tag, input int s, input int w, input int t0);
        int trig;
        chk({tag, "_count"}, acc_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++) begin
            chk({tag, "_ch"}, acc_q[k].ch, exp_q[k].ch);
            chk({tag, "_data"}, acc_q[k].data, exp_q[k].data);
            trig = (k == 0) ? t0 : acc_q[k-1].t;
            if (k < rise_q.size()) chk({tag, "_latency"}, rise_q[k] - trig, eff(s) + eff(w) + 2);
            else                   chk({tag, "_rise_missing"}, 0, 1);
        end
        chk({tag, "_done_count"}, done_q.size(), (exp_q.size() > 0) ? 1 : 0);
        if (done_q.size() > 0 && acc_q.size() > 0)
            chk({tag, "_done_time"}, done_q[0], acc_q[acc_q.size()-1].t + 1);
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    typedef struct {
        logic [2:0] mask;
        int s; int w; bit noise;
        int exp_n; int exp_lat; int exp_ch0; int exp_d0; int exp_chl; int exp_dl;
    } vec_t;

    initial begin
        vec_t tbl [6];
        int t0, n, bad, s, w;
        logic [2:0] m;
        bit noise;
        int cont_ch [6];

        tbl[0] = '{3'b101,   4, 100, 1'b0, 2, 106, 0,    7, 2, 2007};
        tbl[1] = '{3'b010,   0,   0, 1'b0, 1,   4, 1, 1007, 1, 1007};
        tbl[2] = '{3'b001,   1,   1, 1'b1, 1,   4, 0,    7, 0,    7};
        tbl[3] = '{3'b100, 255,   3, 1'b0, 1, 260, 2, 2007, 2, 2007};
        tbl[4] = '{3'b111,   2,   5, 1'b1, 3,   9, 0,    7, 2, 2007};
        tbl[5] = '{3'b000,   3,   3, 1'b0, 0,   0, 0,    0, 0,    0};

        rif.res_ready = 1'b0;
        for (int c = 0; c < NUM_CH; c++) rate[c] = 0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_vco_en", vco_en, 0);
        chk("rst_cnt_clr", cnt_clr, 1);
        chk("rst_ch_sel", ch_sel, 0);
        chk("rst_res_valid", rif.res_valid, 0);
        chk("rst_res_data", rif.res_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sweep_done", sweep_done, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven sweeps, counters static so data = ch*1000+7
        rif.res_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].mask, tbl[i].s, tbl[i].w, tbl[i].noise, t0);
            chk("tbl_count", acc_q.size(), tbl[i].exp_n);
            chk("tbl_busy_after", busy, 0);
            if (tbl[i].exp_n > 0 && acc_q.size() > 0 && rise_q.size() > 0) begin
                chk("tbl_latency", rise_q[0] - t0, tbl[i].exp_lat);
                chk("tbl_first_ch", acc_q[0].ch, tbl[i].exp_ch0);
                chk("tbl_first_data", acc_q[0].data, tbl[i].exp_d0);
                chk("tbl_last_ch", acc_q[acc_q.size()-1].ch, tbl[i].exp_chl);
                chk("tbl_last_data", acc_q[acc_q.size()-1].data, tbl[i].exp_dl);
                chk("tbl_done", done_q.size(), 1);
            end else if (tbl[i].exp_n == 0) begin
                chk("tbl_no_rise", rise_q.size(), 0);
                chk("tbl_no_done", done_q.size(), 0);
            end
        end

        // Randomized sweeps with random back-pressure and counting VCOs
        rmode = 1'b1;
        for (int t = 0; t < 25; t++) begin
            m     = 3'($urandom_range(0, 7));
            s     = $urandom_range(0, 5);
            w     = $urandom_range(0, 20);
            noise = 1'($urandom_range(0, 1));
            for (int c = 0; c < NUM_CH; c++) rate[c] = $urandom_range(0, 3);
            run_sweep(m, s, w, noise, t0);
            if (m != 3'b000) begin
                n = 0;
                while (busy && n < 200) begin tick(); n++; end
            end
            exp_q.delete();
            for (int c = 0; c < NUM_CH; c++)
                if (m[c]) exp_q.push_back('{c, (c * 1000 + 7 + eff(w) * rate[c]) & 16'hFFFF, 0});
            check_sweep("rand", s, w, t0);
        end
        rmode = 1'b0;
        rif.res_ready = 1'b1;

        // Back-pressure: result held 50 cycles with VCO idle and busy high
        clear_obs();
        rif.res_ready = 1'b0;
        rate[0] = 2;
        allow_mask = 3'b001;
        ch_mask = 3'b001; settle_len = 8'd2; win_len = 16'd5;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (!rif.res_valid && n < 100) begin tick(); n++; end
        chk("bp_valid_seen", rif.res_valid, 1);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            if (!(rif.res_valid && rif.res_data == 16'd17 && rif.res_ch == 2'd0 &&
                  vco_en == '0 && busy)) bad++;
            tick();
        end
        chk("bp_stable_bad_cycles", bad, 0);
        chk("bp_no_accept", acc_q.size(), 0);
        rif.res_ready = 1'b1; tick(); rif.res_ready = 1'b0;
        tick(); tick();
        chk("bp_accept_count", acc_q.size(), 1);
        if (acc_q.size() > 0) chk("bp_accept_data", acc_q[0].data, 17);
        chk("bp_done", done_q.size(), 1);
        chk("bp_idle", busy, 0);

        // Continuous: mask change lands at next sweep; dropping continuous ends after current sweep
        clear_obs();
        rif.res_ready = 1'b1;
        rate[0] = 1; rate[1] = 2; rate[2] = 3;
        allow_mask = 3'b111;
        cont_ch[0] = 0; cont_ch[1] = 1; cont_ch[2] = 0;
        cont_ch[3] = 1; cont_ch[4] = 2; cont_ch[5] = 2;
        ch_mask = 3'b011; settle_len = 8'd1; win_len = 16'd3; continuous = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        n = 0;
        while (acc_q.size() < 3 && n < 500) begin tick(); n++; end
        ch_mask = 3'b100;
        n = 0;
        while (acc_q.size() < 5 && n < 500) begin tick(); n++; end
        continuous = 1'b0;
        n = 0;
        while ((busy || done_q.size() < 4) && n < 500) begin tick(); n++; end
        chk("cont_count", acc_q.size(), 6);
        for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
            chk("cont_ch", acc_q[k].ch, cont_ch[k]);
            chk("cont_data", acc_q[k].data, cont_ch[k] * 1000 + 7 + 3 * (cont_ch[k] + 1));
        end
        chk("cont_done_count", done_q.size(), 4);
        for (int k = 0; k < 4 && k < done_busy_q.size(); k++)
            chk("cont_done_busy", done_busy_q[k], (k < 3) ? 1 : 0);
        chk("cont_idle", busy, 0);

        // Reset mid-INTEG aborts with no result
        clear_obs();
        ch_mask = 3'b111; settle_len = 8'd2; win_len = 16'd50;
        start = 1'b1; tick(); start = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        chk("pre_rst_vco_en", vco_en, 1);
        chk("pre_rst_cnt_clr", cnt_clr, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_vco_en", vco_en, 0);
        chk("arst_cnt_clr", cnt_clr, 1);
        chk("arst_ch_sel", ch_sel, 0);
        chk("arst_res_valid", rif.res_valid, 0);
        chk("arst_res_data", rif.res_data, 0);
        chk("arst_res_ch", rif.res_ch, 0);
        chk("arst_busy", busy, 0);
        chk("arst_sweep_done", sweep_done, 0);
        tick(); tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 80; k++) tick();
        chk("arst_no_result", rise_q.size(), 0);
        chk("arst_no_done", done_q.size(), 0);
        chk("arst_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
